// File: rtl/aes_pkg.sv
// Shared GF(2^8) helpers and FSM state type for the iterative (Inv)MixColumns engine.
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return gf_xtime(b);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] b);
    return gf_xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul4(input logic [7:0] b);
    return gf_xtime(gf_xtime(b));
  endfunction

  function automatic logic [7:0] gf_mul8(input logic [7:0] b);
    return gf_xtime(gf_xtime(gf_xtime(b)));
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] b);
    return gf_mul8(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_mulb(input logic [7:0] b);
    return gf_mul8(b) ^ gf_mul2(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_muld(input logic [7:0] b);
    return gf_mul8(b) ^ gf_mul4(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_mule(input logic [7:0] b);
    return gf_mul8(b) ^ gf_mul4(b) ^ gf_mul2(b);
  endfunction

endpackage

// File: rtl/aes_mixcol_word.sv
// Combinational MixColumns transform of one 32-bit column (row 0 = MSB byte).
// The inverse matrix is only built when AES_MIXCOL_INV_EN is defined.
module aes_mixcol_word
  import aes_pkg::*;
(
  input  logic [31:0] col,
  input  logic        inv,
  output logic [31:0] mixed
);

  logic [7:0] a0;
  logic [7:0] a1;
  logic [7:0] a2;
  logic [7:0] a3;
  logic [31:0] fwd;

  assign a0 = col[31:24];
  assign a1 = col[23:16];
  assign a2 = col[15:8];
  assign a3 = col[7:0];

  // Circulant {02 03 01 01}
  assign fwd = {gf_mul2(a0) ^ gf_mul3(a1) ^ a2 ^ a3,
                a0 ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3,
                a0 ^ a1 ^ gf_mul2(a2) ^ gf_mul3(a3),
                gf_mul3(a0) ^ a1 ^ a2 ^ gf_mul2(a3)};

`ifdef AES_MIXCOL_INV_EN
  logic [31:0] bwd;

  // Circulant {0e 0b 0d 09}
  assign bwd = {gf_mule(a0) ^ gf_mulb(a1) ^ gf_muld(a2) ^ gf_mul9(a3),
                gf_mul9(a0) ^ gf_mule(a1) ^ gf_mulb(a2) ^ gf_muld(a3),
                gf_muld(a0) ^ gf_mul9(a1) ^ gf_mule(a2) ^ gf_mulb(a3),
                gf_mulb(a0) ^ gf_muld(a1) ^ gf_mul9(a2) ^ gf_mule(a3)};

  assign mixed = inv ? bwd : fwd;
`else
  logic unused_inv;

  assign unused_inv = inv;
  assign mixed      = fwd;
`endif

endmodule

// File: rtl/aes_mix_columns_iter.sv
// Iterative (Inv)MixColumns over an NB-column Rijndael state, COLS_PER_CYCLE columns per clock.
// Inverse support is compiled in with AES_MIXCOL_INV_EN.
module aes_mix_columns_iter
  import aes_pkg::*;
#(
  parameter int unsigned NB             = 4,
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_inv,
  input  logic [32*NB-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [32*NB-1:0]   out_data,
  output logic               busy
);

  localparam int unsigned CPC = COLS_PER_CYCLE;
  localparam int unsigned CW  = $clog2(NB) + 1;
  localparam int unsigned IW  = $clog2(NB);

  if (!((NB == 4) || (NB == 6) || (NB == 8)) ||
      !((CPC == 1) || (CPC == 2) || (CPC == 4)) ||
      ((NB % CPC) != 0)) begin : g_bad_params
    $error("aes_mix_columns_iter: illegal NB/COLS_PER_CYCLE combination");
  end

  state_e                state;
  logic [CW-1:0]         col_cnt;
  logic [NB-1:0][31:0]   work;
  logic [IW-1:0]         col_idx  [CPC];
  logic [31:0]           word_out [CPC];
  logic                  word_inv;

`ifdef AES_MIXCOL_INV_EN
  logic inv_q;

  assign word_inv = inv_q;
`else
  logic unused_in_inv;

  assign unused_in_inv = in_inv;
  assign word_inv      = 1'b0;
`endif

  // Column c lives in packed slot NB-1-c so that column 0 is the MSB word.
  always_comb begin
    for (int k = 0; k < int'(CPC); k++) begin
      col_idx[k] = '0;
      if ((col_cnt + CW'(k)) < CW'(NB)) begin
        col_idx[k] = IW'(CW'(NB - 1) - col_cnt - CW'(k));
      end
    end
  end

  for (genvar g = 0; g < int'(CPC); g++) begin : g_word
    aes_mixcol_word u_word (
      .col   (work[col_idx[g]]),
      .inv   (word_inv),
      .mixed (word_out[g])
    );
  end

  assign out_data = work;

  // Control FSM with registered handshake/status outputs; the working register doubles as output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      col_cnt   <= '0;
      work      <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
`ifdef AES_MIXCOL_INV_EN
      inv_q     <= 1'b0;
`endif
    end else if (clear) begin
      state     <= IDLE;
      col_cnt   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            work     <= in_data;
            col_cnt  <= '0;
            state    <= BUSY;
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef AES_MIXCOL_INV_EN
            inv_q    <= in_inv;
`endif
          end
        end
        BUSY: begin
          for (int k = 0; k < int'(CPC); k++) begin
            work[col_idx[k]] <= word_out[k];
          end
          col_cnt <= col_cnt + CW'(CPC);
          if (col_cnt == CW'(NB - CPC)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_mix_columns_iter.sv
// Directed bench for aes_mix_columns_iter: three configurations (4/1, 4/4, 8/2).
module tb_aes_mix_columns_iter;

`ifdef AES_MIXCOL_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  localparam logic [127:0] A_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] A_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] B_IN  = 128'hd4d4d4d5_2d26314c_db135345_01010101;
  localparam logic [127:0] B_OUT = 128'hd5d5d7d6_4d7ebdf8_8e4da1bc_01010101;

  logic clk;
  logic reset_n;

  logic         clear_a, in_valid_a, in_ready_a, in_inv_a, out_valid_a, out_ready_a, busy_a;
  logic [127:0] in_data_a, out_data_a;
  logic         clear_b, in_valid_b, in_ready_b, in_inv_b, out_valid_b, out_ready_b, busy_b;
  logic [127:0] in_data_b, out_data_b;
  logic         clear_c, in_valid_c, in_ready_c, in_inv_c, out_valid_c, out_ready_c, busy_c;
  logic [255:0] in_data_c, out_data_c;

  int checks = 0;
  int errors = 0;

  aes_mix_columns_iter #(.NB(4), .COLS_PER_CYCLE(1)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .clear(clear_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_inv(in_inv_a), .in_data(in_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_data(out_data_a), .busy(busy_a)
  );

  aes_mix_columns_iter #(.NB(4), .COLS_PER_CYCLE(4)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .clear(clear_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_inv(in_inv_b), .in_data(in_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_data(out_data_b), .busy(busy_b)
  );

  aes_mix_columns_iter #(.NB(8), .COLS_PER_CYCLE(2)) u_dut_c (
    .clk(clk), .reset_n(reset_n), .clear(clear_c), .in_valid(in_valid_c), .in_ready(in_ready_c),
    .in_inv(in_inv_c), .in_data(in_data_c), .out_valid(out_valid_c), .out_ready(out_ready_c),
    .out_data(out_data_c), .busy(busy_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: shift-and-add GF multiply with a rotating coefficient row.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [31:0] model_col(input logic [31:0] col, input bit inv);
    logic [7:0] coef [4];
    logic [7:0] b [4];
    logic [31:0] r;
    if (inv) begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    for (int j = 0; j < 4; j++) b[j] = col[31-8*j -: 8];
    r = '0;
    for (int row = 0; row < 4; row++) begin
      logic [7:0] acc;
      acc = 8'h00;
      for (int j = 0; j < 4; j++) acc = acc ^ gmul(b[j], coef[(j - row + 4) % 4]);
      r[31-8*row -: 8] = acc;
    end
    return r;
  endfunction

  function automatic logic [255:0] model_state(input logic [255:0] s, input int nb, input bit inv);
    logic [255:0] r;
    r = s;
    for (int c = 0; c < nb; c++) r[32*nb-1-32*c -: 32] = model_col(s[32*nb-1-32*c -: 32], inv);
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  task automatic run_a(input logic [127:0] din, input logic inv, output logic [127:0] dout,
                       output int lat);
    int guard;
    guard = 0;
    in_data_a = din; in_inv_a = inv; in_valid_a = 1'b1; out_ready_a = 1'b0;
    while (!in_ready_a && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    lat = 0;
    while (!out_valid_a && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    dout = out_data_a;
    out_ready_a = 1'b1;
    @(posedge clk); #1;
    out_ready_a = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid_a); end
    checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_a); end
    checks++; if (out_data_a !== 128'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data_a); end
    checks++; if (in_ready_c !== 1'b1) begin errors++; $display("FAIL reset_in_ready_c got %b exp 1", in_ready_c); end
  endtask

  task automatic test_forward;
    logic [127:0] d;
    int lat;
    run_a(A_IN, 1'b0, d, lat);
    checks++; if (d !== A_OUT) begin errors++; $display("FAIL fwd_data got %h exp %h", d, A_OUT); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL fwd_latency got %0d exp 4", lat); end
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL fwd_valid_drop got %b exp 0", out_valid_a); end
    checks++; if (in_ready_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++; $display("FAIL fwd_idle got ready %b busy %b exp 1 0", in_ready_a, busy_a);
    end
  endtask

  task automatic test_inverse;
    logic [127:0] d;
    logic [255:0] fw;
    logic [127:0] exp_d;
    int lat;
    fw = model_state({128'h0, A_OUT}, 4, 1'b0);
    exp_d = INV_EN ? A_IN : fw[127:0];
    run_a(A_OUT, 1'b1, d, lat);
    checks++; if (d !== exp_d) begin errors++; $display("FAIL inv_data got %h exp %h", d, exp_d); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL inv_latency got %0d exp 4", lat); end
  endtask

  task automatic test_cpc4;
    int lat;
    in_data_b = B_IN; in_inv_b = 1'b0; in_valid_b = 1'b1; out_ready_b = 1'b0;
    @(posedge clk); #1;
    in_valid_b = 1'b0;
    lat = 0;
    while (!out_valid_b && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    checks++; if (lat !== 1) begin errors++; $display("FAIL cpc4_latency got %0d exp 1", lat); end
    checks++; if (out_data_b !== B_OUT) begin errors++; $display("FAIL cpc4_data got %h exp %h", out_data_b, B_OUT); end
    out_ready_b = 1'b1;
    @(posedge clk); #1;
    out_ready_b = 1'b0;
    checks++; if (out_valid_b !== 1'b0 || in_ready_b !== 1'b1) begin
      errors++; $display("FAIL cpc4_return got valid %b ready %b exp 0 1", out_valid_b, in_ready_b);
    end
  endtask

  task automatic test_back_to_back;
    logic [255:0] exp_q [$];
    logic [255:0] pd;
    logic [255:0] exp_d;
    int n_tx, sent, recvd, cyc, acc_cyc;
    bit fi, fo, pv;
    n_tx = 12; sent = 0; recvd = 0; cyc = 0; acc_cyc = 0;
    in_data_c = rand256(); in_inv_c = 1'($urandom_range(0, 1)); in_valid_c = 1'b1;
    while (recvd < n_tx && cyc < 3000) begin
      out_ready_c = ($urandom_range(0, 2) != 0);
      fi = in_valid_c && in_ready_c;
      fo = out_valid_c && out_ready_c;
      pv = out_valid_c;
      pd = out_data_c;
      @(posedge clk); #1; cyc++;
      if (fi) begin
        exp_q.push_back(model_state(in_data_c, 8, in_inv_c & INV_EN));
        acc_cyc = cyc;
        sent++;
        if (sent < n_tx) begin
          in_data_c = rand256(); in_inv_c = 1'($urandom_range(0, 1));
        end else begin
          in_valid_c = 1'b0;
        end
      end
      if (fo) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_duplicate got extra output %h", pd);
        end else begin
          exp_d = exp_q.pop_front();
          if (pd !== exp_d) begin errors++; $display("FAIL b2b_data got %h exp %h", pd, exp_d); end
        end
        recvd++;
      end else if (pv) begin
        checks++;
        if (out_valid_c !== 1'b1 || out_data_c !== pd) begin
          errors++; $display("FAIL b2b_stall got valid %b data %h exp 1 %h", out_valid_c, out_data_c, pd);
        end
      end
      if (!pv && out_valid_c) begin
        checks++;
        if (cyc - acc_cyc !== 4) begin errors++; $display("FAIL b2b_latency got %0d exp 4", cyc - acc_cyc); end
      end
    end
    out_ready_c = 1'b0;
    in_valid_c = 1'b0;
    checks++;
    if (recvd !== n_tx || sent !== n_tx || exp_q.size() !== 0) begin
      errors++; $display("FAIL b2b_count got sent %0d recvd %0d pending %0d exp %0d %0d 0", sent, recvd, exp_q.size(), n_tx, n_tx);
    end
  endtask

  task automatic test_abort;
    logic [127:0] d;
    int lat;
    // clear at col_cnt = 2
    in_data_a = B_IN; in_inv_a = 1'b0; in_valid_a = 1'b1;
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    repeat (2) @(posedge clk);
    #1 clear_a = 1'b1;
    @(posedge clk); #1;
    clear_a = 1'b0;
    checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++; $display("FAIL clear_idle got valid %b ready %b busy %b exp 0 1 0", out_valid_a, in_ready_a, busy_a);
    end
    run_a(A_IN, 1'b0, d, lat);
    checks++; if (d !== A_OUT || lat !== 4) begin
      errors++; $display("FAIL clear_next got %h lat %0d exp %h lat 4", d, lat, A_OUT);
    end
    // asynchronous reset at col_cnt = 2
    in_data_a = B_IN; in_valid_a = 1'b1;
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++; $display("FAIL rst_idle got valid %b ready %b busy %b exp 0 1 0", out_valid_a, in_ready_a, busy_a);
    end
    checks++; if (out_data_a !== 128'h0) begin errors++; $display("FAIL rst_data got %h exp 0", out_data_a); end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_a(A_IN, 1'b0, d, lat);
    checks++; if (d !== A_OUT || lat !== 4) begin
      errors++; $display("FAIL rst_next got %h lat %0d exp %h lat 4", d, lat, A_OUT);
    end
  endtask

  task automatic test_hold_valid;
    int cyc, nacc, acc0, acc1, g;
    bit fire, seen_out;
    logic [127:0] first_out;
    cyc = 0; nacc = 0; acc0 = 0; acc1 = 0; seen_out = 1'b0; first_out = '0;
    in_data_a = A_IN; in_inv_a = 1'b0; in_valid_a = 1'b1; out_ready_a = 1'b1;
    while (nacc < 2 && cyc < 60) begin
      fire = in_valid_a && in_ready_a;
      if (out_valid_a && !seen_out) begin
        seen_out = 1'b1; first_out = out_data_a;
      end
      @(posedge clk); #1; cyc++;
      if (fire) begin
        if (nacc == 0) acc0 = cyc; else acc1 = cyc;
        nacc++;
      end
    end
    in_valid_a = 1'b0;
    checks++; if (nacc !== 2) begin errors++; $display("FAIL hold_accepts got %0d exp 2", nacc); end
    checks++; if (acc1 - acc0 !== 6) begin errors++; $display("FAIL hold_period got %0d exp 6", acc1 - acc0); end
    checks++; if (!seen_out || first_out !== A_OUT) begin
      errors++; $display("FAIL hold_first got seen %b data %h exp 1 %h", seen_out, first_out, A_OUT);
    end
    g = 0;
    while (!out_valid_a && g < 50) begin
      @(posedge clk); #1; g++;
    end
    checks++; if (out_valid_a !== 1'b1 || out_data_a !== A_OUT) begin
      errors++; $display("FAIL hold_second got valid %b data %h exp 1 %h", out_valid_a, out_data_a, A_OUT);
    end
    @(posedge clk); #1;
    out_ready_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
      errors++; $display("FAIL hold_no_third got valid %b ready %b exp 0 1", out_valid_a, in_ready_a);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    clear_a = 1'b0; in_valid_a = 1'b0; in_inv_a = 1'b0; out_ready_a = 1'b0; in_data_a = '0;
    clear_b = 1'b0; in_valid_b = 1'b0; in_inv_b = 1'b0; out_ready_b = 1'b0; in_data_b = '0;
    clear_c = 1'b0; in_valid_c = 1'b0; in_inv_c = 1'b0; out_ready_c = 1'b0; in_data_c = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    test_forward();
    test_inverse();
    test_cpc4();
    test_back_to_back();
    test_abort();
    test_hold_valid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
